// File: rtl/dsm_pkg.sv
// Shared definitions for the delta-sigma front end: sequencer state
// encoding and default datapath widths.
package dsm_pkg;

    localparam int DSM_DATA_W = 33;
    localparam int DSM_CNT_W  = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_DRAIN  = 2'd3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-bit pointers; a push into a full FIFO is
// accepted when a pop happens in the same cycle. dout reads zero when empty.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !(rst || flush)) mem[wr_ptr[PTR_W-1:0]] <= din;
    end

endmodule

// File: rtl/cic_sequencer.sv
// Sequences a CIC decimator: resets it on start, generates the decimation
// strobe, discards settling outputs and buffers the rest for a consumer.
module cic_sequencer
    import dsm_pkg::*;
#(
    parameter int DATA_W     = DSM_DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = DSM_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [CNT_W-1:0]  cfg_ratio,
    input  logic [CNT_W-1:0]  cfg_settle,
    output logic              cic_rst,
    output logic              dec_tick,
    input  logic [DATA_W-1:0] cic_out,
    input  logic              cic_out_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [1:0]        state,
    output logic              overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [1:0]       state_q;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] ratio_q;
    logic [CNT_W-1:0] settle_q;
    logic [CNT_W-1:0] discard_q;
    logic [CNT_W-1:0] tick_cnt_q;
    logic             cic_rst_q;
    logic             dec_tick_q;
    logic             overflow_q;
    logic             accept_start;
    logic             push;
    logic             pop;
    logic             drop;
    logic             tick_wrap;
    logic             active_nxt;
    logic             fifo_full;
    logic             fifo_empty;
    logic [PTR_W:0]   fifo_count;

    assign accept_start = (state_q == ST_IDLE) && start && !stop;
    assign pop          = m_valid && m_ready;
    assign push         = (state_q == ST_RUN) && cic_out_valid;
    assign drop         = push && fifo_full && !m_ready;
    assign tick_wrap    = (tick_cnt_q == ratio_q - 1'b1);
    assign active_nxt   = (state_nxt == ST_SETTLE) || (state_nxt == ST_RUN);

    // Samples arriving while the CIC is still held in reset are not counted.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_start) state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else if (cic_rst_q) begin
                    if (settle_q == '0) state_nxt = ST_RUN;
                end else if (cic_out_valid && (discard_q + 1'b1 == settle_q)) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (fifo_empty || (pop && fifo_count == {{PTR_W{1'b0}}, 1'b1}))
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ratio_q    <= CNT_W'(2);
            settle_q   <= '0;
            discard_q  <= '0;
            cic_rst_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            cic_rst_q <= accept_start;
            if (accept_start) begin
                ratio_q    <= (cfg_ratio < CNT_W'(2)) ? CNT_W'(2) : cfg_ratio;
                settle_q   <= cfg_settle;
                discard_q  <= '0;
                overflow_q <= 1'b0;
            end else begin
                if (state_q == ST_SETTLE && !cic_rst_q && cic_out_valid)
                    discard_q <= discard_q + 1'b1;
                if (drop) overflow_q <= 1'b1;
            end
        end
    end

    // The strobe is registered so the first pulse lands R cycles after cic_rst falls.
    always_ff @(posedge clk) begin
        if (rst || accept_start || cic_rst_q || !active_nxt) begin
            tick_cnt_q <= '0;
            dec_tick_q <= 1'b0;
        end else begin
            dec_tick_q <= tick_wrap;
            tick_cnt_q <= tick_wrap ? '0 : tick_cnt_q + 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (accept_start),
        .push  (push),
        .pop   (pop),
        .din   (cic_out),
        .dout  (m_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign m_valid  = !fifo_empty;
    assign cic_rst  = rst || cic_rst_q;
    assign dec_tick = dec_tick_q;
    assign overflow = overflow_q;
    assign state    = state_q;

endmodule

// File: tb/tb_cic_sequencer.sv
// Self-checking bench for cic_sequencer: directed scenarios plus random
// traffic, all compared every cycle against a queue-based reference model.
module tb_cic_sequencer;

    localparam int DATA_W = 33;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              stop;
    logic [CNT_W-1:0]  cfg_ratio;
    logic [CNT_W-1:0]  cfg_settle;
    logic              cic_rst;
    logic              dec_tick;
    logic [DATA_W-1:0] cic_out;
    logic              cic_out_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic [1:0]        state;
    logic              overflow;

    int checks = 0;
    int fails  = 0;
    int cycleNo = 0;

    // Reference model: mode 0..3, buffered samples, sticky flag and time since cic_rst fell.
    int                mMode = 0;
    logic [DATA_W-1:0] mQ[$];
    bit                mOvf  = 1'b0;
    bit                mCicr = 1'b0;
    bit                mTick = 1'b0;
    int                mR    = 2;
    int                mS    = 0;
    int                mDisc = 0;
    int                mT    = 0;

    always #5 clk = ~clk;

    cic_sequencer #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .stop          (stop),
        .cfg_ratio     (cfg_ratio),
        .cfg_settle    (cfg_settle),
        .cic_rst       (cic_rst),
        .dec_tick      (dec_tick),
        .cic_out       (cic_out),
        .cic_out_valid (cic_out_valid),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .state         (state),
        .overflow      (overflow)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cycleNo);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic p,
                                 input logic [CNT_W-1:0] ratio, input logic [CNT_W-1:0] settle,
                                 input logic v, input logic [DATA_W-1:0] d, input logic rdy);
        rst           = r;
        start         = s;
        stop          = p;
        cfg_ratio     = ratio;
        cfg_settle    = settle;
        cic_out_valid = v;
        cic_out       = d;
        m_ready       = rdy;
    endtask

    task automatic modelUpdate();
        int  newMode;
        bit  oldCicr;
        bit  accepted;
        if (rst) begin
            mMode = 0;
            mQ.delete();
            mOvf  = 1'b0;
            mCicr = 1'b0;
            mTick = 1'b0;
            mT    = 0;
            return;
        end
        oldCicr  = mCicr;
        newMode  = mMode;
        accepted = 1'b0;
        if (mQ.size() > 0 && m_ready) void'(mQ.pop_front());
        case (mMode)
            0: if (start && !stop) begin
                newMode  = 1;
                accepted = 1'b1;
                mR       = (int'(cfg_ratio) < 2) ? 2 : int'(cfg_ratio);
                mS       = int'(cfg_settle);
                mDisc    = 0;
                mOvf     = 1'b0;
                mQ.delete();
            end
            1: if (stop) newMode = 0;
               else if (oldCicr) begin
                   if (mS == 0) newMode = 2;
               end else if (cic_out_valid) begin
                   mDisc++;
                   if (mDisc == mS) newMode = 2;
               end
            2: begin
                if (cic_out_valid) begin
                    if (mQ.size() < DEPTH) mQ.push_back(cic_out);
                    else mOvf = 1'b1;
                end
                if (stop) newMode = 3;
            end
            default: if (mQ.size() == 0) newMode = 0;
        endcase
        if (accepted) begin
            mCicr = 1'b1;
            mT    = 0;
        end else begin
            mT    = oldCicr ? 0 : mT + 1;
            mCicr = 1'b0;
        end
        mMode = newMode;
        mTick = (mMode == 1 || mMode == 2) && !mCicr && mT > 0 && (mT % mR) == 0;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        modelUpdate();
        @(negedge clk);
        cycleNo++;
        checkOutput("state", 64'(state), 64'(mMode));
        checkOutput("cic_rst", 64'(cic_rst), 64'(rst | mCicr));
        checkOutput("dec_tick", 64'(dec_tick), 64'(mTick));
        checkOutput("m_valid", 64'(m_valid), 64'(mQ.size() > 0));
        checkOutput("m_data", 64'(m_data), (mQ.size() > 0) ? 64'(mQ[0]) : 64'd0);
        checkOutput("overflow", 64'(overflow), 64'(mOvf));
    endtask

    task automatic doReset();
        applyStimulus(1, 0, 0, 0, 0, 0, '0, 0);
        stepCycle();
        stepCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, '0, 0);
    endtask

    task automatic startRun(input int ratio, input int settle, input logic rdy);
        applyStimulus(0, 1, 0, CNT_W'(ratio), CNT_W'(settle), 0, '0, rdy);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, '0, rdy);
        stepCycle();
    endtask

    task automatic feedSample(input logic [DATA_W-1:0] d, input logic rdy);
        applyStimulus(0, 0, 0, 0, 0, 1, d, rdy);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, '0, rdy);
    endtask

    initial begin
        logic [DATA_W-1:0] got[$];
        logic [DATA_W-1:0] sent[$];
        logic [63:0]       rnd;
        int first;
        int second;
        int xfers;
        int ticks;

        applyStimulus(1, 0, 0, 0, 0, 0, '0, 0);
        doReset();

        // Decimation strobe spacing with R=32 and no settling.
        applyStimulus(0, 1, 0, 8'd32, 8'd0, 0, '0, 1);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, '0, 1);
        first  = 0;
        second = 0;
        for (int k = 1; k <= 100; k++) begin
            stepCycle();
            if (dec_tick) begin
                if (first == 0) first = k;
                else if (second == 0) second = k;
            end
        end
        checkOutput("tick_first", 64'(first), 64'd33);
        checkOutput("tick_gap", 64'(second - first), 64'd32);

        // Settle discards the first three samples.
        doReset();
        startRun(4, 3, 0);
        for (int i = 1; i <= 6; i++) feedSample(DATA_W'(i), 0);
        got.delete();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, '0, 1);
            if (m_valid) got.push_back(m_data);
            stepCycle();
        end
        checkOutput("settle_count", 64'(got.size()), 64'd3);
        for (int i = 0; i < 3; i++)
            checkOutput($sformatf("settle_data%0d", i), (i < got.size()) ? 64'(got[i]) : '1, 64'(i + 4));

        // Overflow with a stalled consumer, then the buffered four drain intact.
        doReset();
        startRun(2, 0, 0);
        sent.delete();
        for (int i = 0; i < 6; i++) begin
            sent.push_back(33'h1_0000_0000 + DATA_W'(i * 17 + 3));
            feedSample(sent[i], 0);
        end
        checkOutput("ovf_set", 64'(overflow), 64'd1);
        got.delete();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, '0, 1);
            if (m_valid) got.push_back(m_data);
            stepCycle();
        end
        checkOutput("ovf_drain_count", 64'(got.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("ovf_data%0d", i), (i < got.size()) ? 64'(got[i]) : '1, 64'(sent[i]));

        // Full FIFO with a simultaneous pop accepts the new sample.
        doReset();
        startRun(2, 0, 0);
        for (int i = 0; i < 4; i++) feedSample(DATA_W'(40 + i), 0);
        checkOutput("full_valid", 64'(m_valid), 64'd1);
        feedSample(DATA_W'(99), 1);
        checkOutput("full_pop_ovf", 64'(overflow), 64'd0);
        checkOutput("full_pop_head", 64'(m_data), 64'd41);

        // Stop in RUN drains three samples and returns to IDLE.
        doReset();
        startRun(2, 0, 0);
        for (int i = 0; i < 3; i++) feedSample(DATA_W'(70 + i), 0);
        applyStimulus(0, 0, 1, 0, 0, 0, '0, 0);
        stepCycle();
        xfers = 0;
        ticks = 0;
        for (int i = 0; i < 10 && state != 2'd0; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, '0, 1);
            if (m_valid) xfers++;
            stepCycle();
            if (dec_tick) ticks++;
        end
        checkOutput("drain_xfers", 64'(xfers), 64'd3);
        checkOutput("drain_ticks", 64'(ticks), 64'd0);
        checkOutput("drain_idle", 64'(state), 64'd0);

        // Reset mid-run discards buffered samples.
        doReset();
        startRun(2, 0, 0);
        for (int i = 0; i < 2; i++) feedSample(DATA_W'(80 + i), 0);
        applyStimulus(1, 0, 0, 0, 0, 0, '0, 1);
        stepCycle();
        checkOutput("rst_valid", 64'(m_valid), 64'd0);
        checkOutput("rst_state", 64'(state), 64'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, '0, 0);
        stepCycle();

        // Random traffic against the reference model.
        for (int i = 0; i < 4000; i++) begin
            rnd = {$urandom(), $urandom()};
            applyStimulus($urandom_range(0, 299) == 0,
                          $urandom_range(0, 15) == 0,
                          $urandom_range(0, 39) == 0,
                          CNT_W'($urandom_range(0, 6)),
                          CNT_W'($urandom_range(0, 3)),
                          $urandom_range(0, 1) == 1,
                          rnd[DATA_W-1:0],
                          ((i / 500) % 2 == 1) ? ($urandom_range(0, 3) == 0)
                                               : ($urandom_range(0, 3) != 0));
            stepCycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/cic_sequencer.md
CIC_SEQUENCER -- requirements
Module: cic_sequencer

Interface
REQ-001 Parameter DATA_W, default 33: width of CIC output samples and of m_data.
REQ-002 Parameter FIFO_DEPTH, default 4: output buffer depth in entries; power of two, at least 2.
REQ-003 Parameter CNT_W, default 8: width of cfg_ratio, cfg_settle and the internal counters.
REQ-004 clk  in  1  clock; all logic is rising-edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  single-cycle request to begin a conversion run.
REQ-007 stop  in  1  single-cycle request to end a conversion run.
REQ-008 cfg_ratio  in  CNT_W  decimation factor R; sampled on an accepted start.
REQ-009 cfg_settle  in  CNT_W  number of CIC outputs to discard after start; sampled on an accepted start.
REQ-010 cic_rst  out  1  reset drive to the CIC datapath.
REQ-011 dec_tick  out  1  decimation strobe to the CIC comb section.
REQ-012 cic_out  in  DATA_W  signed CIC output sample.
REQ-013 cic_out_valid  in  1  cic_out qualifier.
REQ-014 m_data  out  DATA_W  buffered output sample.
REQ-015 m_valid  out  1  m_data is valid.
REQ-016 m_ready  in  1  consumer accepts m_data.
REQ-017 state  out  2  current FSM state: IDLE=0, SETTLE=1, RUN=2, DRAIN=3.
REQ-018 overflow  out  1  sticky flag: a sample was dropped.

Function
REQ-019 FSM transitions:
- IDLE→SETTLE on start with stop low.
- SETTLE→RUN once cfg_settle valid samples have been discarded.
- SETTLE→IDLE on stop.
- RUN→DRAIN on stop.
- DRAIN→IDLE on the cycle the FIFO becomes empty.
REQ-020 An accepted start latches R = max(cfg_ratio, 2) and the settle count, clears overflow and the FIFO, and drives cic_rst high for exactly the following cycle.
REQ-021 start outside IDLE is ignored. When start and stop arrive in the same cycle in IDLE, the FSM stays in IDLE.
REQ-022 A cfg_settle of 0 moves the FSM directly from SETTLE to RUN on the cycle after cic_rst deasserts.
REQ-023 In SETTLE and RUN, dec_tick is a one-cycle pulse every R cycles, driven by a counter running 0..R-1. The first pulse comes R cycles after cic_rst deasserts.
REQ-024 dec_tick is held low in IDLE and DRAIN, and the tick counter resets to 0 on leaving RUN.
REQ-025 In SETTLE, cic_out_valid samples are counted and discarded. The sample that completes the count is also discarded.
REQ-026 In RUN, each cic_out_valid sample is pushed into the FIFO.
REQ-027 A push when the FIFO is full and m_ready is low drops the sample and sets overflow.
REQ-028 A push when the FIFO is full and m_ready is high is accepted, because the simultaneous pop frees a slot.
REQ-029 Samples arriving in IDLE or DRAIN are ignored and do not set overflow.
REQ-030 Handshake: a transfer occurs when m_valid and m_ready are both high. m_data stays stable while m_valid is high and m_ready is low.
REQ-031 Latency: a sample pushed into an empty FIFO appears on m_data with m_valid high on the next cycle.
REQ-032 FIFO pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by an extra pointer bit.
REQ-033 Sample data passes through the block unmodified; no arithmetic is applied to it.

Reset
REQ-034 rst overrides all other inputs. The FSM returns to IDLE and the FIFO is emptied.
REQ-035 During and after rst: cic_rst=1 while rst is high and 0 afterwards; dec_tick=0; m_valid=0; m_data=0; overflow=0; state=0.
REQ-036 rst asserted mid-run discards FIFO contents with no partial transfer.

Structure
REQ-037 A shared package dsm_pkg holds the state encoding, a DATA_W default of 33 and a CNT_W default of 8.
REQ-038 The FIFO is one sub-module, sync_fifo, parameterised by width and depth, with push, pop, full, empty and flush ports.

Verification
REQ-039 R=32, settle=0, start: dec_tick pulses 32 cycles apart, the first 32 cycles after cic_rst falls.
REQ-040 R=4, settle=3, six samples 1..6 injected: m_data delivers 4, 5, 6 in order.
REQ-041 FIFO_DEPTH=4, m_ready=0, six samples: four are buffered, overflow=1, and the first four drain intact.
REQ-042 Full FIFO with m_ready=1 and a simultaneous sample: no drop, overflow stays 0.
REQ-043 stop in RUN with 3 buffered samples: dec_tick stops, 3 transfers occur, then state returns to IDLE.
REQ-044 rst asserted mid-RUN with 2 buffered samples: the next cycle shows m_valid=0 and state=IDLE.
